avn_mem_arbiter: RTL and testbench
==================================

Name: avn_mem_arbiter

Overview:
- Shares one Avalon-MM memory port between NUM_REQ cache/bus masters, for example the instruction-side and data-side dir_cache instances, or a non-cacheable MMIO path.
- Sits between the caches' mem_avn_req/mem_avn_resp ports and the system memory/interconnect.
- Sequences ownership of the memory bus:
  - locks the grant across waitrequest stalls;
  - tracks the owner of the 1-cycle-latency read data;
  - supports fixed-priority or round-robin scheduling.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- ARB_SCHEME, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_avn_req  input  NUM_REQ x avalon_req_t  requests from each master (read, write, address, byte_enable, writedata).
- req_avn_resp  output  NUM_REQ x avalon_resp_t  responses to each master (waitrequest, readdata).
- mem_avn_req  output  avalon_req_t  request to memory.
- mem_avn_resp  input  avalon_resp_t  response from memory.
- rd_owner  output  $clog2(NUM_REQ) (min 1)  index of the master whose read was accepted last cycle (debug/visibility).
- rd_valid  output  1  mem readdata this cycle belongs to rd_owner.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst). Reset clears the following:
  - state = IDLE; lock_owner = 0;
  - rr_ptr = NUM_REQ-1, so master 0 has first priority after reset;
  - rd_valid = 0; rd_owner = 0.
- Behaviour while rst is high:
  - mem_avn_req.read/write = 0;
  - every master asserting read|write sees waitrequest = 1.
- Request of master i: req_i = read | write.
- Grant is combinational:
  - state LOCKED: grant = lock_owner.
  - state IDLE, fixed priority: grant = lowest i with req_i.
  - state IDLE, round-robin: grant = first i with req_i scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - No requests: no grant; mem_avn_req.read/write = 0; address/data driven from index 0 (don't care).
- Grant never depends combinationally on mem_avn_resp.waitrequest. This is required because dir_cache drives its memory read/write from the hit result and drives core waitrequest from mem waitrequest; any such dependency would form a combinational loop.
- Muxing: mem_avn_req = req_avn_req[grant].
- Waitrequest per master:
  - granted master = mem_avn_resp.waitrequest;
  - non-granted requesting master = 1;
  - idle master = 0.
- Acceptance: accept = granted req & ~mem_avn_resp.waitrequest. Zero added latency: a granted request in IDLE with waitrequest=0 completes in the same cycle.
- FSM, states IDLE and LOCKED:
  - IDLE -> LOCKED when a grant exists and mem waitrequest = 1; lock_owner <= grant.
  - LOCKED -> IDLE on accept.
  - LOCKED -> IDLE if lock_owner drops read|write (Avalon violation, defensive release; no memory transfer is counted).
  - LOCKED holds while waitrequest = 1. A higher-priority arrival never preempts.
- Multi-transfer sequences (dirty flush followed by fill from one dir_cache) re-arbitrate between the write and the read. Each transfer is individually atomic.
- Round-robin pointer: rr_ptr <= grant on every accept. In fixed-priority mode rr_ptr is unused.
- Read return, 1-cycle latency:
  - rd_valid <= accept & read; rd_owner <= grant on a read accept.
  - mem_avn_resp.readdata is broadcast to all req_avn_resp[i].readdata. Each master qualifies it with its own accepted-read flag.
  - A new accept in the same cycle as a readdata return is legal; pipelined back-to-back reads from different masters are supported.
- Simultaneous read & write from one master is illegal. It is passed through unchanged.
- Reset asserted mid-transfer: lock and rd_valid clear immediately (async). The pending transfer is abandoned; memory is expected to be reset by the same rst.

Decomposition:
- Shared package (core.svh / core package): avalon_req_t and avalon_resp_t, already present.
- Add to the same package: ARB_FIXED = 0 and ARB_RR = 1 constants, and the arb_state_t enum {IDLE, LOCKED}.
- One sub-module: rr_arbiter.
  - Purely combinational NUM_REQ-wide priority picker.
  - Inputs: req vector, rr_ptr, scheme. Outputs: one-hot grant plus encoded index.
  - Lock FSM, pointer and read-owner registers stay in avn_mem_arbiter.

Test Plan:
- Single master 0 read of 0x0000_0100, mem waitrequest = 0: mem read same cycle, master 0 waitrequest = 0. Next cycle rd_valid = 1, rd_owner = 0, readdata 0xDEAD_BEEF on port 0.
- Masters 0 and 1 both read, RR, after reset: master 0 granted first and master 1 sees waitrequest = 1. The next accept goes to master 1, then alternation 0, 1, 0 while both keep requesting. With ARB_SCHEME = 0, master 0 wins every cycle.
- Master 1 write 0x8000_0010 = 0x1234_5678 with mem waitrequest held 3 cycles; master 0 request arrives in cycle 2: state stays LOCKED, mem_avn_req remains master 1's write. Master 0 sees waitrequest = 1 until cycle 4, then is granted.
- Back-to-back reads master 0 at cycle 0, master 1 at cycle 1, zero wait: rd_owner = 0 at cycle 1, rd_owner = 1 at cycle 2, rd_valid high in both cycles.
- dir_cache-style dirty flush (write) then fill (read) from master 0 while master 1 is requesting under RR: master 1 is granted between the two transfers. No combinational loop is reported by lint/simulation.
- Assert rst while LOCKED with waitrequest = 1: mem read/write drop to 0 asynchronously, rd_valid = 0. After release, the first grant goes to master 0.

Source files
------------

// File: rtl/avn_mem_arbiter_pkg.sv
// Shared Avalon-MM request/response types and memory-arbiter constants.
package avn_mem_arbiter_pkg;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [3:0]  byte_enable;
      logic [31:0] writedata;
   } avalon_req_t;

   typedef struct packed {
      logic        waitrequest;
      logic [31:0] readdata;
   } avalon_resp_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/avn_mem_arbiter_rr.sv
// Combinational priority picker: fixed (lowest index) or round-robin after rr_ptr.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   input  logic                       scheme,
   output logic [NUM_REQ-1:0]         grant_oh,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_valid
);

   localparam int IW = $clog2(NUM_REQ);

   always_comb begin
      logic [IW-1:0] pos;
      grant_oh    = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      pos         = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         // Round-robin scans rr_ptr+1, rr_ptr+2, ... so the last winner goes last.
         if (scheme) pos = IW'((32'(rr_ptr) + k + 32'd1) % NUM_REQ);
         else        pos = IW'(k);
         if (!grant_valid && req[pos]) begin
            grant_valid   = 1'b1;
            grant_oh[pos] = 1'b1;
            grant_idx     = pos;
         end
      end
   end

endmodule

// File: rtl/avn_mem_arbiter.sv
// Shares one Avalon-MM memory port between NUM_REQ masters; locks the grant across
// waitrequest stalls and tracks which master owns the 1-cycle-latency read data.
module avn_mem_arbiter
   import avn_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ARB_SCHEME = ARB_RR
) (
   input  logic                         clk,
   input  logic                         rst,
   input  avalon_req_t  [NUM_REQ-1:0]   req_avn_req,
   output avalon_resp_t [NUM_REQ-1:0]   req_avn_resp,
   output avalon_req_t                  mem_avn_req,
   input  avalon_resp_t                 mem_avn_resp,
   output logic [$clog2(NUM_REQ)-1:0]   rd_owner,
   output logic                         rd_valid
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_t          state_q, state_d;
   logic [IW-1:0]       lock_owner_q, lock_owner_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                rd_valid_q, rd_valid_d;
   logic [IW-1:0]       rd_owner_q, rd_owner_d;

   logic [NUM_REQ-1:0]  req_vec;
   logic [NUM_REQ-1:0]  arb_oh;
   logic [IW-1:0]       arb_idx;
   logic                arb_valid;

   logic [NUM_REQ-1:0]  gnt_oh;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_valid;
   logic                accept;
   logic                read_accept;

   always_comb begin
      req_vec = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_vec[i] = req_avn_req[i].read | req_avn_req[i].write;
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req         (req_vec),
      .rr_ptr      (rr_ptr_q),
      .scheme      (ARB_SCHEME == ARB_RR),
      .grant_oh    (arb_oh),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // Grant is a function of state and requests only, never of mem waitrequest.
   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = arb_idx;
      gnt_valid = arb_valid;
      if (state_q == LOCKED) begin
         gnt_idx               = lock_owner_q;
         gnt_valid             = req_vec[lock_owner_q];
         gnt_oh[lock_owner_q]  = req_vec[lock_owner_q];
      end else begin
         gnt_oh = arb_oh;
      end
   end

   always_comb begin
      mem_avn_req = req_avn_req[gnt_idx];
      if (!gnt_valid || rst) begin
         mem_avn_req.read  = 1'b0;
         mem_avn_req.write = 1'b0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_avn_resp[i].readdata    = mem_avn_resp.readdata;
         req_avn_resp[i].waitrequest = 1'b0;
         if (req_vec[i]) begin
            if (rst || !gnt_oh[i]) req_avn_resp[i].waitrequest = 1'b1;
            else                   req_avn_resp[i].waitrequest = mem_avn_resp.waitrequest;
         end
      end
   end

   assign accept      = gnt_valid & ~mem_avn_resp.waitrequest & ~rst;
   assign read_accept = accept & req_avn_req[gnt_idx].read;

   always_comb begin
      state_d      = state_q;
      lock_owner_d = lock_owner_q;
      rr_ptr_d     = accept ? gnt_idx : rr_ptr_q;
      rd_valid_d   = read_accept;
      rd_owner_d   = read_accept ? gnt_idx : rd_owner_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid && mem_avn_resp.waitrequest) begin
               state_d      = LOCKED;
               lock_owner_d = gnt_idx;
            end
         end
         LOCKED: begin
            // Owner dropping its request mid-stall releases the lock without a transfer.
            if (!gnt_valid || accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         lock_owner_q <= '0;
         rr_ptr_q     <= IW'(NUM_REQ - 1);
         rd_valid_q   <= 1'b0;
         rd_owner_q   <= '0;
      end else begin
         state_q      <= state_d;
         lock_owner_q <= lock_owner_d;
         rr_ptr_q     <= rr_ptr_d;
         rd_valid_q   <= rd_valid_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_owner = rd_owner_q;

endmodule

// File: tb/tb_avn_mem_arbiter.sv
// Directed bench for avn_mem_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_avn_mem_arbiter;
   import avn_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   avalon_req_t  [1:0] req;
   avalon_resp_t       mem_resp;
   avalon_resp_t [1:0] resp_rr, resp_fp;
   avalon_req_t        mem_rr, mem_fp;
   logic               rd_owner_rr, rd_owner_fp;
   logic               rd_valid_rr, rd_valid_fp;

   int n_checks = 0;
   int n_fail   = 0;

   avn_mem_arbiter #(.NUM_REQ(2), .ARB_SCHEME(ARB_RR)) dut_rr (
      .clk(clk), .rst(rst), .req_avn_req(req), .req_avn_resp(resp_rr),
      .mem_avn_req(mem_rr), .mem_avn_resp(mem_resp), .rd_owner(rd_owner_rr), .rd_valid(rd_valid_rr)
   );

   avn_mem_arbiter #(.NUM_REQ(2), .ARB_SCHEME(ARB_FIXED)) dut_fp (
      .clk(clk), .rst(rst), .req_avn_req(req), .req_avn_resp(resp_fp),
      .mem_avn_req(mem_fp), .mem_avn_resp(mem_resp), .rd_owner(rd_owner_fp), .rd_valid(rd_valid_fp)
   );

   function automatic avalon_req_t mk(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      avalon_req_t r;
      r.read = rd; r.write = wr; r.address = a; r.byte_enable = 4'hF; r.writedata = d;
      return r;
   endfunction

   task automatic clear_reqs();
      req[0] = mk(1'b0, 1'b0, 32'h0, 32'h0);
      req[1] = mk(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      clear_reqs();
      mem_resp.waitrequest = 1'b0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_reqs();
      req[0] = mk(1'b1, 1'b0, 32'h100, 32'h0);
      mem_resp.waitrequest = 1'b0;
      mem_resp.readdata = 32'h0;
      #3;
      n_checks++; if (mem_rr.read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %0b expected 0", mem_rr.read); end
      n_checks++; if (resp_rr[0].waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait0: got %0b expected 1", resp_rr[0].waitrequest); end
      n_checks++; if (rd_valid_rr !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid_rr); end
      n_checks++; if (rd_owner_rr !== 1'b0) begin n_fail++; $display("FAIL reset_rd_owner: got %0b expected 0", rd_owner_rr); end
      next_cycle();
      clear_reqs();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      next_cycle();
      req[0] = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0);
      mem_resp.waitrequest = 1'b0;
      #2;
      n_checks++; if (mem_rr.read !== 1'b1 || mem_rr.address !== 32'h100) begin n_fail++; $display("FAIL single_mem_req: got rd=%0b addr=%h expected rd=1 addr=00000100", mem_rr.read, mem_rr.address); end
      n_checks++; if (resp_rr[0].waitrequest !== 1'b0) begin n_fail++; $display("FAIL single_wait0: got %0b expected 0", resp_rr[0].waitrequest); end
      next_cycle();
      clear_reqs();
      mem_resp.readdata = 32'hDEAD_BEEF;
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1 || rd_owner_rr !== 1'b0) begin n_fail++; $display("FAIL single_rd_return: got valid=%0b owner=%0b expected valid=1 owner=0", rd_valid_rr, rd_owner_rr); end
      n_checks++; if (resp_rr[0].readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_readdata: got %h expected deadbeef", resp_rr[0].readdata); end
      next_cycle();
      n_checks++; if (rd_valid_rr !== 1'b0) begin n_fail++; $display("FAIL single_rd_valid_drop: got %0b expected 0", rd_valid_rr); end
   endtask

   task automatic test_rr_alternation();
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'h1000; exp_addr[1] = 32'h2000; exp_addr[2] = 32'h1000; exp_addr[3] = 32'h2000;
      pulse_reset();
      for (int c = 0; c < 4; c++) begin
         req[0] = mk(1'b1, 1'b0, 32'h1000, 32'h0);
         req[1] = mk(1'b1, 1'b0, 32'h2000, 32'h0);
         #2;
         n_checks++; if (mem_rr.address !== exp_addr[c]) begin n_fail++; $display("FAIL rr_grant c%0d: got addr %h expected %h", c, mem_rr.address, exp_addr[c]); end
         n_checks++; if (resp_rr[(c % 2 == 0) ? 1 : 0].waitrequest !== 1'b1) begin n_fail++; $display("FAIL rr_loser_wait c%0d: got 0 expected 1", c); end
         n_checks++; if (mem_fp.address !== 32'h1000 || resp_fp[1].waitrequest !== 1'b1) begin n_fail++; $display("FAIL fp_grant c%0d: got addr %h wait1=%0b expected addr 00001000 wait1=1", c, mem_fp.address, resp_fp[1].waitrequest); end
         if (c > 0) begin
            n_checks++; if (rd_owner_rr !== ((c % 2 == 1) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rr_rd_owner c%0d: got %0b expected %0b", c, rd_owner_rr, (c % 2 == 1) ? 1'b0 : 1'b1); end
         end
         next_cycle();
      end
      clear_reqs();
   endtask

   task automatic test_locked();
      pulse_reset();
      req[1] = mk(1'b0, 1'b1, 32'h8000_0010, 32'h1234_5678);
      mem_resp.waitrequest = 1'b1;
      #2;
      n_checks++; if (mem_rr.write !== 1'b1 || mem_rr.writedata !== 32'h1234_5678) begin n_fail++; $display("FAIL lock_c0_write: got wr=%0b data=%h expected wr=1 data=12345678", mem_rr.write, mem_rr.writedata); end
      next_cycle();
      next_cycle();
      req[0] = mk(1'b1, 1'b0, 32'h1000, 32'h0);
      #2;
      n_checks++; if (mem_rr.address !== 32'h8000_0010 || mem_rr.write !== 1'b1) begin n_fail++; $display("FAIL lock_c2_hold_rr: got addr=%h wr=%0b expected addr=80000010 wr=1", mem_rr.address, mem_rr.write); end
      n_checks++; if (mem_fp.address !== 32'h8000_0010) begin n_fail++; $display("FAIL lock_c2_no_preempt_fp: got addr=%h expected 80000010", mem_fp.address); end
      n_checks++; if (resp_rr[0].waitrequest !== 1'b1 || resp_rr[1].waitrequest !== 1'b1) begin n_fail++; $display("FAIL lock_c2_waits: got w0=%0b w1=%0b expected 1 1", resp_rr[0].waitrequest, resp_rr[1].waitrequest); end
      next_cycle();
      mem_resp.waitrequest = 1'b0;
      #2;
      n_checks++; if (resp_rr[1].waitrequest !== 1'b0 || resp_rr[0].waitrequest !== 1'b1 || mem_rr.address !== 32'h8000_0010) begin n_fail++; $display("FAIL lock_c3_accept: got w0=%0b w1=%0b addr=%h expected 1 0 80000010", resp_rr[0].waitrequest, resp_rr[1].waitrequest, mem_rr.address); end
      next_cycle();
      req[1] = mk(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      n_checks++; if (mem_rr.read !== 1'b1 || mem_rr.address !== 32'h1000 || resp_rr[0].waitrequest !== 1'b0) begin n_fail++; $display("FAIL lock_c4_grant0: got rd=%0b addr=%h w0=%0b expected 1 00001000 0", mem_rr.read, mem_rr.address, resp_rr[0].waitrequest); end
      n_checks++; if (rd_valid_rr !== 1'b0) begin n_fail++; $display("FAIL lock_write_no_rd_valid: got %0b expected 0", rd_valid_rr); end
      next_cycle();
      clear_reqs();
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1 || rd_owner_rr !== 1'b0) begin n_fail++; $display("FAIL lock_c5_rd: got valid=%0b owner=%0b expected 1 0", rd_valid_rr, rd_owner_rr); end
   endtask

   task automatic test_back_to_back();
      next_cycle();
      mem_resp.waitrequest = 1'b0;
      req[0] = mk(1'b1, 1'b0, 32'h1000, 32'h0);
      next_cycle();
      req[0] = mk(1'b0, 1'b0, 32'h0, 32'h0);
      req[1] = mk(1'b1, 1'b0, 32'h2000, 32'h0);
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1 || rd_owner_rr !== 1'b0) begin n_fail++; $display("FAIL b2b_c1: got valid=%0b owner=%0b expected 1 0", rd_valid_rr, rd_owner_rr); end
      n_checks++; if (mem_rr.address !== 32'h2000 || resp_rr[1].waitrequest !== 1'b0) begin n_fail++; $display("FAIL b2b_c1_grant1: got addr=%h w1=%0b expected 00002000 0", mem_rr.address, resp_rr[1].waitrequest); end
      next_cycle();
      clear_reqs();
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1 || rd_owner_rr !== 1'b1) begin n_fail++; $display("FAIL b2b_c2: got valid=%0b owner=%0b expected 1 1", rd_valid_rr, rd_owner_rr); end
      n_checks++; if (rd_valid_fp !== 1'b1 || rd_owner_fp !== 1'b1) begin n_fail++; $display("FAIL b2b_c2_fp: got valid=%0b owner=%0b expected 1 1", rd_valid_fp, rd_owner_fp); end
   endtask

   task automatic test_flush_fill();
      pulse_reset();
      req[0] = mk(1'b0, 1'b1, 32'h3000, 32'hAAAA_5555);
      req[1] = mk(1'b1, 1'b0, 32'h4000, 32'h0);
      #2;
      n_checks++; if (mem_rr.write !== 1'b1 || mem_rr.address !== 32'h3000 || resp_rr[1].waitrequest !== 1'b1) begin n_fail++; $display("FAIL flush_c0: got wr=%0b addr=%h w1=%0b expected 1 00003000 1", mem_rr.write, mem_rr.address, resp_rr[1].waitrequest); end
      next_cycle();
      req[0] = mk(1'b1, 1'b0, 32'h5000, 32'h0);
      #2;
      n_checks++; if (mem_rr.read !== 1'b1 || mem_rr.address !== 32'h4000 || resp_rr[0].waitrequest !== 1'b1) begin n_fail++; $display("FAIL flush_c1_m1_between: got rd=%0b addr=%h w0=%0b expected 1 00004000 1", mem_rr.read, mem_rr.address, resp_rr[0].waitrequest); end
      next_cycle();
      req[1] = mk(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      n_checks++; if (mem_rr.address !== 32'h5000 || resp_rr[0].waitrequest !== 1'b0 || rd_owner_rr !== 1'b1) begin n_fail++; $display("FAIL flush_c2_fill: got addr=%h w0=%0b owner=%0b expected 00005000 0 1", mem_rr.address, resp_rr[0].waitrequest, rd_owner_rr); end
      next_cycle();
      clear_reqs();
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1 || rd_owner_rr !== 1'b0) begin n_fail++; $display("FAIL flush_c3_rd: got valid=%0b owner=%0b expected 1 0", rd_valid_rr, rd_owner_rr); end
   endtask

   task automatic test_reset_locked();
      pulse_reset();
      req[0] = mk(1'b1, 1'b0, 32'h1000, 32'h0);
      next_cycle();
      clear_reqs();
      #2;
      n_checks++; if (rd_valid_rr !== 1'b1) begin n_fail++; $display("FAIL rstlk_pre_rd_valid: got %0b expected 1", rd_valid_rr); end
      rst = 1'b1;
      #1;
      n_checks++; if (rd_valid_rr !== 1'b0) begin n_fail++; $display("FAIL rstlk_async_rd_valid: got %0b expected 0", rd_valid_rr); end
      next_cycle();
      rst = 1'b0;
      req[1] = mk(1'b0, 1'b1, 32'h80, 32'h5);
      mem_resp.waitrequest = 1'b1;
      next_cycle();
      #2;
      n_checks++; if (mem_rr.write !== 1'b1 || resp_rr[1].waitrequest !== 1'b1) begin n_fail++; $display("FAIL rstlk_locked: got wr=%0b w1=%0b expected 1 1", mem_rr.write, resp_rr[1].waitrequest); end
      rst = 1'b1;
      #1;
      n_checks++; if (mem_rr.write !== 1'b0 || mem_rr.read !== 1'b0 || resp_rr[1].waitrequest !== 1'b1) begin n_fail++; $display("FAIL rstlk_async_drop: got wr=%0b rd=%0b w1=%0b expected 0 0 1", mem_rr.write, mem_rr.read, resp_rr[1].waitrequest); end
      next_cycle();
      rst = 1'b0;
      mem_resp.waitrequest = 1'b0;
      req[0] = mk(1'b1, 1'b0, 32'h1000, 32'h0);
      #2;
      n_checks++; if (mem_rr.read !== 1'b1 || mem_rr.address !== 32'h1000) begin n_fail++; $display("FAIL rstlk_first_grant_rr: got rd=%0b addr=%h expected 1 00001000", mem_rr.read, mem_rr.address); end
      n_checks++; if (mem_fp.read !== 1'b1 || mem_fp.address !== 32'h1000) begin n_fail++; $display("FAIL rstlk_first_grant_fp: got rd=%0b addr=%h expected 1 00001000", mem_fp.read, mem_fp.address); end
      next_cycle();
      clear_reqs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_rr_alternation();
      test_locked();
      test_back_to_back();
      test_flush_fill();
      test_reset_locked();
      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
